prog_loader: RTL and testbench

- Run controller that sits directly upstream of the X9 core top level.
- Accepts a byte stream of machine code and packs it into 9-bit instructions written into instruction memory.
- Holds the core in reset while loading, then releases it and counts cycles until the core raises done (or a timeout).
- Reports completion to the host with a req/ack handshake.

---
 rtl/x9_loader_pkg.sv | 22 ++
 rtl/sat_counter.sv | 32 +++
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/x9_loader_pkg.sv
// Shared types and default widths for the X9 program loader.
package x9_loader_pkg;

    // Default instruction memory address width (program counter width)
    localparam int D_DEFAULT  = 12;
    // Default instruction width
    localparam int W_DEFAULT  = 9;
    // Default cycle counter width
    localparam int CW_DEFAULT = 16;
    // Each instruction arrives as two bytes, low byte first
    localparam int BYTES_PER_INSTR = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_LO = 3'd1,
        LOAD_HI = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          sat
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_reg;

    assign sat = (cnt_reg == CNT_MAX);
    assign cnt = cnt_reg;

    // Count register: clear wins over enable, enable is ignored once saturated
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (en && !sat) begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Run controller for the X9 core: packs a byte stream into instruction
// memory, runs the core out of reset, counts cycles and reports to the host.
module prog_loader
    import x9_loader_pkg::*;
#(
    parameter int D  = D_DEFAULT,
    parameter int W  = W_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          im_wr_en,
    output logic [D-1:0]  im_addr,
    output logic [W-1:0]  im_wr_data,
    output logic          core_reset,
    input  logic          core_done,
    output logic          ack,
    output logic          err,
    output logic          timeout,
    output logic [CW-1:0] cyc_cnt,
    output logic [D:0]    n_instr
);

    localparam logic [D-1:0] WPTR_MAX = '1;
    localparam logic [D-1:0] WPTR_ONE = D'(1);
    localparam logic [D:0]   NINS_ONE = (D+1)'(1);

    state_t state_reg, state_next;

    logic [7:0]   lo_reg;
    logic [D-1:0] wptr_reg;
    logic [D:0]   n_instr_reg;
    logic         im_wr_en_reg;
    logic [D-1:0] im_addr_reg;
    logic [W-1:0] im_wr_data_reg;
    logic         core_reset_reg;
    logic         ack_reg;
    logic         err_reg;
    logic         timeout_reg;

    logic         xfer;
    logic         start;
    logic         wr_fire;
    logic         timeout_fire;
    logic         cnt_en;
    logic         cnt_sat;
    logic [W-1:0] packed_instr;

    // Only the low bit of the high byte is meaningful for a 9-bit instruction
    assign packed_instr = {ld_data[W-9:0], lo_reg};
    assign ld_ready     = (state_reg == LOAD_LO) || (state_reg == LOAD_HI);
    assign xfer         = ld_valid && ld_ready;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-cycle strobes; a dropped req aborts any active phase
    always_comb begin
        state_next   = state_reg;
        start        = 1'b0;
        wr_fire      = 1'b0;
        timeout_fire = 1'b0;
        cnt_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    state_next = LOAD_LO;
                    start      = 1'b1;
                end
            end
            LOAD_LO: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    // A last byte here means the image has an odd byte count
                    state_next = ld_last ? ERR : LOAD_HI;
                end
            end
            LOAD_HI: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (xfer) begin
                    wr_fire = 1'b1;
                    if (ld_last) begin
                        state_next = RUN;
                    end else if (wptr_reg == WPTR_MAX) begin
                        state_next = ERR;
                    end else begin
                        state_next = LOAD_LO;
                    end
                end
            end
            RUN: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (core_done) begin
                    state_next = DONE;
                end else if (cnt_sat) begin
                    state_next   = DONE;
                    timeout_fire = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE, ERR: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; status flags follow the state being entered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_reg         <= '0;
            wptr_reg       <= '0;
            n_instr_reg    <= '0;
            im_wr_en_reg   <= 1'b0;
            im_addr_reg    <= '0;
            im_wr_data_reg <= '0;
            core_reset_reg <= 1'b1;
            ack_reg        <= 1'b0;
            err_reg        <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            im_wr_en_reg   <= wr_fire;
            core_reset_reg <= (state_next != RUN);
            ack_reg        <= (state_next == DONE);
            err_reg        <= (state_next == ERR);
            if (state_reg == LOAD_LO && xfer) begin
                lo_reg <= ld_data;
            end
            if (start) begin
                wptr_reg    <= '0;
                n_instr_reg <= '0;
                timeout_reg <= 1'b0;
            end else if (wr_fire) begin
                im_addr_reg    <= wptr_reg;
                im_wr_data_reg <= packed_instr;
                wptr_reg       <= wptr_reg + WPTR_ONE;
                n_instr_reg    <= n_instr_reg + NINS_ONE;
            end
            if (timeout_fire) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (cnt_en),
        .cnt   (cyc_cnt),
        .sat   (cnt_sat)
    );

    assign im_wr_en   = im_wr_en_reg;
    assign im_addr    = im_addr_reg;
    assign im_wr_data = im_wr_data_reg;
    assign core_reset = core_reset_reg;
    assign ack        = ack_reg;
    assign err        = err_reg;
    assign timeout    = timeout_reg;
    assign n_instr    = n_instr_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table-driven byte loads with a write scoreboard,
// plus hand-written run, timeout, error, abort and reset sequences.
module tb_prog_loader;

    localparam int D  = 4;
    localparam int W  = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req;
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          im_wr_en;
    logic [D-1:0]  im_addr;
    logic [W-1:0]  im_wr_data;
    logic          core_reset;
    logic          core_done;
    logic          ack;
    logic          err;
    logic          timeout;
    logic [CW-1:0] cyc_cnt;
    logic [D:0]    n_instr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]   data;
        logic         last;
        logic         gap;
        logic         exp_wr;
        logic [D-1:0] exp_addr;
        logic [W-1:0] exp_data;
    } vec_t;

    wr_t  sb[$];
    vec_t tab[$];
    wr_t  mon_e;

    prog_loader #(.D(D), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .im_wr_en   (im_wr_en),
        .im_addr    (im_addr),
        .im_wr_data (im_wr_data),
        .core_reset (core_reset),
        .core_done  (core_done),
        .ack        (ack),
        .err        (err),
        .timeout    (timeout),
        .cyc_cnt    (cyc_cnt),
        .n_instr    (n_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [7:0] data, input logic last, input logic gap,
                       input logic exp_wr, input logic [D-1:0] addr, input logic [W-1:0] wdata);
        vec_t v;
        v.data = data; v.last = last; v.gap = gap;
        v.exp_wr = exp_wr; v.exp_addr = addr; v.exp_data = wdata;
        tab.push_back(v);
    endtask

    // Present one byte and hold it until the loader takes it (bounded wait)
    task automatic send_byte(input logic [7:0] data, input logic last, input logic gap);
        int n;
        if (gap) begin
            ld_valid = 1'b0;
            ld_data  = 8'hEE;
            ld_last  = 1'b1;
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        n = 0;
        while (ld_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ld_ready_wait: got 0 expected 1 within 20 cycles");
        end else begin
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Expected writes go to the scoreboard as the byte that triggers them is driven
    task automatic apply_table();
        wr_t w;
        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].exp_wr) begin
                w.addr = tab[i].exp_addr;
                w.data = tab[i].exp_data;
                sb.push_back(w);
            end
            send_byte(tab[i].data, tab[i].last, tab[i].gap);
        end
        tab.delete();
    endtask

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (im_wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", im_addr, im_wr_data);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", 32'(im_addr), 32'(mon_e.addr));
                check("wr_data", 32'(im_wr_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lo_b, hi_b;
        int n;
        reset = 1'b1; req = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        ld_last = 1'b0; core_done = 1'b0;
        #1;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_ld_ready",   32'(ld_ready),   32'd0);
        check("rst_im_wr_en",   32'(im_wr_en),   32'd0);
        check("rst_im_addr",    32'(im_addr),    32'd0);
        check("rst_im_wr_data", 32'(im_wr_data), 32'd0);
        check("rst_ack",        32'(ack),        32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_timeout",    32'(timeout),    32'd0);
        check("rst_cyc_cnt",    32'(cyc_cnt),    32'd0);
        check("rst_n_instr",    32'(n_instr),    32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        check("idle_ld_ready", 32'(ld_ready), 32'd0);

        // Three-instruction load then normal completion on the 5th run cycle
        req = 1'b1;
        tick();
        check("load_ld_ready", 32'(ld_ready), 32'd1);
        add(8'h12, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
        add(8'h01, 1'b0, 1'b0, 1'b1, 4'd0, 9'h112);
        add(8'h34, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
        add(8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 9'h034);
        add(8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
        add(8'h01, 1'b1, 1'b0, 1'b1, 4'd2, 9'h1FF);
        apply_table();
        check("l3_n_instr",    32'(n_instr),    32'd3);
        check("l3_core_reset", 32'(core_reset), 32'd0);
        check("l3_ld_ready",   32'(ld_ready),   32'd0);
        repeat (4) tick();
        check("run_cyc_cnt4", 32'(cyc_cnt), 32'd4);
        check("run_ack",      32'(ack),     32'd0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("done_cyc_cnt",    32'(cyc_cnt),    32'd4);
        check("done_ack",        32'(ack),        32'd1);
        check("done_timeout",    32'(timeout),    32'd0);
        check("done_core_reset", 32'(core_reset), 32'd1);
        check("done_ld_ready",   32'(ld_ready),   32'd0);
        check("done_sb_empty",   32'(sb.size()),  32'd0);
        req = 1'b0;
        tick();
        check("idle_ack",        32'(ack),        32'd0);
        check("idle_core_reset", 32'(core_reset), 32'd1);

        // Odd byte count: single last byte must raise err and never write
        req = 1'b1;
        tick();
        add(8'hAA, 1'b1, 1'b0, 1'b0, 4'd0, 9'h000);
        apply_table();
        check("odd_err",        32'(err),        32'd1);
        check("odd_core_reset", 32'(core_reset), 32'd1);
        check("odd_ld_ready",   32'(ld_ready),   32'd0);
        core_done = 1'b1;
        repeat (3) tick();
        core_done = 1'b0;
        check("odd_err_held",   32'(err),        32'd1);
        check("odd_no_ack",     32'(ack),        32'd0);
        check("odd_core_rst2",  32'(core_reset), 32'd1);
        req = 1'b0;
        tick();
        check("odd_err_clear",  32'(err),        32'd0);

        // Timeout with a 4-bit counter and core_done never raised
        req = 1'b1;
        tick();
        add(8'h05, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
        add(8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 9'h005);
        apply_table();
        n = 0;
        while (ack !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to_ack",     32'(ack),     32'd1);
        check("to_cyc_cnt", 32'(cyc_cnt), 32'd15);
        check("to_timeout", 32'(timeout), 32'd1);
        repeat (3) tick();
        check("to_cyc_held",  32'(cyc_cnt),  32'd15);
        check("to_ld_ready",  32'(ld_ready), 32'd0);
        req = 1'b0;
        tick();

        // Backpressure: valid low every other cycle with junk data on the bus
        req = 1'b1;
        tick();
        check("bp_timeout_clr", 32'(timeout), 32'd0);
        add(8'h80, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000);
        add(8'h01, 1'b0, 1'b1, 1'b1, 4'd0, 9'h180);
        add(8'h7E, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000);
        add(8'hFE, 1'b0, 1'b1, 1'b1, 4'd1, 9'h07E);
        add(8'h3C, 1'b0, 1'b1, 1'b0, 4'd0, 9'h000);
        add(8'h03, 1'b1, 1'b1, 1'b1, 4'd2, 9'h13C);
        apply_table();
        check("bp_ld_ready_run", 32'(ld_ready), 32'd0);
        check("bp_n_instr",      32'(n_instr),  32'd3);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        check("bp_ack",     32'(ack),     32'd1);
        check("bp_cyc_cnt", 32'(cyc_cnt), 32'd0);
        req = 1'b0;
        tick();

        // Memory full without a last byte ends in err after 2^D instructions
        req = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            lo_b = 8'(i * 5 + 3);
            hi_b = 8'(i + 16);
            add(lo_b, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
            add(hi_b, 1'b0, 1'b0, 1'b1, 4'(i), {hi_b[0], lo_b});
        end
        apply_table();
        check("full_err",        32'(err),        32'd1);
        check("full_n_instr",    32'(n_instr),    32'd16);
        check("full_core_reset", 32'(core_reset), 32'd1);
        req = 1'b0;
        tick();

        // Abort mid-load: dropping req returns to idle with no ack
        req = 1'b1;
        tick();
        send_byte(8'h11, 1'b0, 1'b0);
        req = 1'b0;
        tick();
        check("abort_ld_ready",   32'(ld_ready),   32'd0);
        check("abort_core_reset", 32'(core_reset), 32'd1);
        check("abort_ack",        32'(ack),        32'd0);

        // Asynchronous reset between clock edges during RUN
        req = 1'b1;
        tick();
        add(8'h01, 1'b0, 1'b0, 1'b0, 4'd0, 9'h000);
        add(8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 9'h001);
        apply_table();
        repeat (3) tick();
        check("ar_cyc_cnt3",    32'(cyc_cnt),    32'd3);
        check("ar_core_reset0", 32'(core_reset), 32'd0);
        #3;
        reset = 1'b1;
        #1;
        check("ar_core_reset", 32'(core_reset), 32'd1);
        check("ar_ack",        32'(ack),        32'd0);
        check("ar_cyc_cnt",    32'(cyc_cnt),    32'd0);
        check("ar_n_instr",    32'(n_instr),    32'd0);
        req = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
